alu_ctrl_issue: RTL and testbench
=================================

Name: alu_ctrl_issue

Overview:
- ID-side producer of the ALU control interface.
- Decodes each RV32 instruction into the 4-bit ALU control code and the two ALU operands, then registers them toward EX through a 2-entry skid buffer with valid/ready handshake.
- Sits between register-file read and the EX-stage ALU.
- Supports upstream stalls on downstream back-pressure, and pipeline flush.

Parameters:
- DW, 32, operand/data width.
- DEPTH, 2, skid-buffer entries (fixed at 2; other values unsupported).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  upstream holds a valid instruction.
- ready_o  output  1  block can accept this cycle.
- instr_i  input  32  RV32 instruction word.
- rs1_data_i  input  DW  register-file read data 1.
- rs2_data_i  input  DW  register-file read data 2.
- flush_i  input  1  discard all buffered entries.
- valid_o  output  1  head entry valid toward EX.
- ready_i  input  1  EX consumes the head entry.
- ALUCtrl_o  output  4  ALU operation code.
- data1_o  output  DW  ALU operand 1.
- data2_o  output  DW  ALU operand 2.
- illegal_o  output  1  head entry decoded as unsupported.

Behaviour:
- Reset (rst_i low, asynchronous): buffer emptied; valid_o=0, ready_o=1, ALUCtrl_o=4'b0000, data1_o=0, data2_o=0, illegal_o=0.
- Decode is combinational on instr_i. opcode = instr[6:0], funct3 = instr[14:12], funct7 = instr[31:25].
- R-type (0110011):
  - funct7=0000000, funct3=111 -> 0000 (AND)
  - funct7=0000000, funct3=100 -> 0001 (XOR)
  - funct7=0000000, funct3=001 -> 0010 (SLL)
  - funct7=0000000, funct3=000 -> 0011 (ADD)
  - funct7=0100000, funct3=000 -> 0100 (SUB)
  - funct7=0000001, funct3=000 -> 0101 (MUL)
- I-ALU (0010011):
  - funct3=000 -> 0110 (ADDI)
  - funct3=101 with funct7=0100000 -> 0111 (SRAI)
- Load (0000011, funct3=010) and store (0100011, funct3=010) -> 1000 (address add).
- Branch (1100011, funct3=000) -> 1001 (BEQ).
- Anything else: ALUCtrl=0011 (ADD), operands zero, illegal=1. The entry still flows through the buffer.
- Operand rules:
  - data1 = rs1_data_i always.
  - data2 = rs2_data_i for R-type and branch.
  - data2 = sign-extended instr[31:20] for I-ALU and load.
  - For SRAI, data2 = zero-extended instr[24:20].
  - data2 = sign-extended {instr[31:25], instr[11:7]} for store.
- Handshake:
  - Accept occurs when valid_i && ready_o.
  - Pop occurs when valid_o && ready_i.
  - Latency: an accepted entry appears at valid_o on the next clock edge when the buffer was empty.
  - ready_o = (count < 2), driven from registered count only, with no combinational path from ready_i.
- Count transitions, count in {0,1,2}:
  - accept only: +1.
  - pop only: -1.
  - accept and pop in the same cycle: unchanged, order preserved.
  - Accept at count=2 is impossible because ready_o=0.
- Storage: entries held in a 2-slot FIFO with wrap-around read/write pointers. Outputs are driven from the head slot. Outputs hold their values while valid_o && !ready_i.
- Flush: on a rising edge with flush_i=1, count becomes 0 and valid_o=0 next cycle. Any simultaneous accept is dropped and any simultaneous pop completes (no double-effect). Output data registers may retain stale values but valid_o=0.
- Reset mid-operation discards all entries immediately.
- Overflow/underflow: no arithmetic here; immediates are pure bit-slicing.

Decomposition:
- Shared package holds:
  - ALU control codes: ALU_AND, ALU_XOR, ALU_SLL, ALU_ADD, ALU_SUB, ALU_MUL, ALU_ADDI, ALU_SRAI, ALU_MEM, ALU_BEQ.
  - Opcode constants: OP_R, OP_I, OP_LD, OP_ST, OP_BR.
  - funct7 constants.
- Sub-module alu_ctrl_decode: combinational, instr/rs data in -> {ALUCtrl, data1, data2, illegal} out.
- Top level owns the skid FIFO and handshake.

Test Plan:
- Reset then idle -> valid_o=0, ready_o=1, ALUCtrl_o=0.
- Single SUB (instr 0x40208033, rs1=10, rs2=3), ready_i=1 -> next cycle valid_o=1, ALUCtrl_o=4'b0100, data1=10, data2=3; cleared the following cycle.
- SRAI x1,x1,4 (0x4040D093), rs1=0xFFFFFF00 -> ALUCtrl=0111, data2=4. SW with imm -8 -> ALUCtrl=1000, data2=0xFFFFFFF8.
- Back-pressure: ready_i=0 for 4 cycles while 3 instructions are offered back-to-back -> first two accepted, ready_o=0 after the second, third held upstream. Release ready_i -> all three delivered in order with no loss or duplication.
- Flush with count=2 and a simultaneous accept -> next cycle valid_o=0, ready_o=1; the flushed entries never appear.
- Undefined opcode 0x0000007F -> illegal_o=1, ALUCtrl_o=0011, data1=data2=0. Async reset asserted mid-stall -> valid_o drops without waiting for a clock.

Source files
------------

// File: rtl/alu_ctrl_issue_pkg.sv
// Shared constants for the ID-side ALU control issue block: ALU operation codes,
// RV32 opcodes and the funct3/funct7 values the decoder recognises.
package alu_ctrl_issue_pkg;

    // ALU operation codes sent to EX
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_ADDI = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;
    localparam logic [3:0] ALU_MEM  = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;

    // Major opcodes
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // funct7 values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32 decoder: instruction word plus register-file data in,
// ALU control code, both operands and an illegal flag out.
module alu_ctrl_decode
    import alu_ctrl_issue_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [31:0]   instr_i,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    output logic [3:0]    alu_ctrl_o,
    output logic [DW-1:0] data1_o,
    output logic [DW-1:0] data2_o,
    output logic          illegal_o
);

    logic [6:0]    opcode;
    logic [6:0]    funct7;
    logic [2:0]    funct3;
    logic [DW-1:0] imm_i;
    logic [DW-1:0] imm_s;
    logic [DW-1:0] shamt;
    logic [DW-1:0] op2;
    logic [3:0]    ctrl;
    logic          legal;
    logic          unused_reg_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Immediates are pure bit-slicing; no arithmetic happens here
    assign imm_i = {{(DW-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{(DW-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign shamt = {{(DW-5){1'b0}}, instr_i[24:20]};

    // rs1 index is consumed by the register file upstream, not by this decoder
    assign unused_reg_fields = ^instr_i[19:15];

    // Classify the instruction and pick the ALU code and second operand
    always_comb begin
        ctrl  = ALU_ADD;
        op2   = '0;
        legal = 1'b0;
        case (opcode)
            OP_R: begin
                op2   = rs2_data_i;
                legal = 1'b1;
                if (funct7 == F7_BASE && funct3 == F3_AND)        ctrl = ALU_AND;
                else if (funct7 == F7_BASE && funct3 == F3_XOR)   ctrl = ALU_XOR;
                else if (funct7 == F7_BASE && funct3 == F3_SLL)   ctrl = ALU_SLL;
                else if (funct7 == F7_BASE && funct3 == F3_ADD)   ctrl = ALU_ADD;
                else if (funct7 == F7_ALT && funct3 == F3_ADD)    ctrl = ALU_SUB;
                else if (funct7 == F7_MULDIV && funct3 == F3_ADD) ctrl = ALU_MUL;
                else                                              legal = 1'b0;
            end
            OP_I: begin
                if (funct3 == F3_ADD) begin
                    ctrl  = ALU_ADDI;
                    op2   = imm_i;
                    legal = 1'b1;
                end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
                    ctrl  = ALU_SRAI;
                    op2   = shamt;
                    legal = 1'b1;
                end
            end
            OP_LD: begin
                if (funct3 == F3_W) begin
                    ctrl  = ALU_MEM;
                    op2   = imm_i;
                    legal = 1'b1;
                end
            end
            OP_ST: begin
                if (funct3 == F3_W) begin
                    ctrl  = ALU_MEM;
                    op2   = imm_s;
                    legal = 1'b1;
                end
            end
            OP_BR: begin
                if (funct3 == F3_BEQ) begin
                    ctrl  = ALU_BEQ;
                    op2   = rs2_data_i;
                    legal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Unsupported encodings become a harmless ADD of zeros flagged illegal
    always_comb begin
        alu_ctrl_o = legal ? ctrl : ALU_ADD;
        data1_o    = legal ? rs1_data_i : '0;
        data2_o    = legal ? op2 : '0;
        illegal_o  = ~legal;
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID-side issue stage for the ALU: decodes each instruction and queues the result
// toward EX through a 2-entry skid FIFO with valid/ready handshakes and flush.
module alu_ctrl_issue
    import alu_ctrl_issue_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [31:0]   instr_i,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    input  logic          flush_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [3:0]    ALUCtrl_o,
    output logic [DW-1:0] data1_o,
    output logic [DW-1:0] data2_o,
    output logic          illegal_o
);

    localparam logic [1:0] CountFull = 2'(DEPTH);

    logic [3:0]    dec_ctrl;
    logic [DW-1:0] dec_data1;
    logic [DW-1:0] dec_data2;
    logic          dec_illegal;

    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          accept;
    logic          pop;

    logic [3:0]    ctrl_q    [DEPTH];
    logic [DW-1:0] data1_q   [DEPTH];
    logic [DW-1:0] data2_q   [DEPTH];
    logic          illegal_q [DEPTH];

    alu_ctrl_decode #(
        .DW (DW)
    ) u_decode (
        .instr_i    (instr_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .alu_ctrl_o (dec_ctrl),
        .data1_o    (dec_data1),
        .data2_o    (dec_data2),
        .illegal_o  (dec_illegal)
    );

    // ready_o depends only on registered occupancy, never on ready_i
    assign ready_o = (count_q < CountFull);
    assign valid_o = (count_q != 2'd0);
    // A flush swallows any same-cycle accept
    assign accept  = valid_i & ready_o & ~flush_i;
    assign pop     = valid_o & ready_i;

    // Occupancy and pointer next-state
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (accept) wr_ptr_d = ~wr_ptr_q;
            if (pop)    rd_ptr_d = ~rd_ptr_q;
            case ({accept, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: ;
            endcase
        end
    end

    // Occupancy and pointer registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; slots are cleared on reset so idle outputs read as zero
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctrl_q[i]    <= '0;
                data1_q[i]   <= '0;
                data2_q[i]   <= '0;
                illegal_q[i] <= 1'b0;
            end
        end else if (accept) begin
            ctrl_q[wr_ptr_q]    <= dec_ctrl;
            data1_q[wr_ptr_q]   <= dec_data1;
            data2_q[wr_ptr_q]   <= dec_data2;
            illegal_q[wr_ptr_q] <= dec_illegal;
        end
    end

    // Head slot drives EX directly; it holds while EX stalls
    always_comb begin
        ALUCtrl_o = ctrl_q[rd_ptr_q];
        data1_o   = data1_q[rd_ptr_q];
        data2_o   = data2_q[rd_ptr_q];
        illegal_o = illegal_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: directed scenarios with literal
// expectations, then randomized traffic compared against a queue-based model.
module tb_alu_ctrl_issue;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [31:0]   instr_i;
    logic [DW-1:0] rs1_data_i;
    logic [DW-1:0] rs2_data_i;
    logic          flush_i;
    logic          valid_o;
    logic          ready_i;
    logic [3:0]    ALUCtrl_o;
    logic [DW-1:0] data1_o;
    logic [DW-1:0] data2_o;
    logic          illegal_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ill;
    } entry_t;

    entry_t mq[$];

    always #5 clk_i = ~clk_i;

    alu_ctrl_issue #(
        .DW    (DW),
        .DEPTH (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .instr_i    (instr_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .ALUCtrl_o  (ALUCtrl_o),
        .data1_o    (data1_o),
        .data2_o    (data2_o),
        .illegal_o  (illegal_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_head(input string tag, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic ill);
        check({tag, "_valid"}, valid_o, 1);
        check({tag, "_ctrl"}, ALUCtrl_o, c);
        check({tag, "_data1"}, data1_o, a);
        check({tag, "_data2"}, data2_o, b);
        check({tag, "_illegal"}, illegal_o, ill);
    endtask

    // Reference decode written straight from the instruction-set rules
    function automatic entry_t ref_decode(input logic [31:0] i, input logic [31:0] a,
                                          input logic [31:0] b);
        entry_t r;
        logic [6:0]  op   = i[6:0];
        logic [2:0]  f3   = i[14:12];
        logic [6:0]  f7   = i[31:25];
        logic [11:0] immi = i[31:20];
        logic [11:0] imms = {i[31:25], i[11:7]};
        int          sxi  = $signed(immi);
        int          sxs  = $signed(imms);
        r.d1  = a;
        r.ill = 1'b0;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7)      begin r.ctrl = 4'd0; r.d2 = b; end
        else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) begin r.ctrl = 4'd1; r.d2 = b; end
        else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd1) begin r.ctrl = 4'd2; r.d2 = b; end
        else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin r.ctrl = 4'd3; r.d2 = b; end
        else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin r.ctrl = 4'd4; r.d2 = b; end
        else if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd0) begin r.ctrl = 4'd5; r.d2 = b; end
        else if (op == 7'h13 && f3 == 3'd0) begin r.ctrl = 4'd6; r.d2 = 32'(sxi); end
        else if (op == 7'h13 && f3 == 3'd5 && f7 == 7'h20) begin
            r.ctrl = 4'd7;
            r.d2   = 32'(i[24:20]);
        end
        else if (op == 7'h03 && f3 == 3'd2) begin r.ctrl = 4'd8; r.d2 = 32'(sxi); end
        else if (op == 7'h23 && f3 == 3'd2) begin r.ctrl = 4'd8; r.d2 = 32'(sxs); end
        else if (op == 7'h63 && f3 == 3'd0) begin r.ctrl = 4'd9; r.d2 = b; end
        else begin
            r.ctrl = 4'd3;
            r.d1   = '0;
            r.d2   = '0;
            r.ill  = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd  = 5'($urandom);
        logic [4:0]  ra  = 5'($urandom);
        logic [4:0]  rb  = 5'($urandom);
        logic [11:0] imm = 12'($urandom);
        logic [31:0] w;
        case ($urandom_range(0, 14))
            0:  w = {7'h00, rb, ra, 3'd7, rd, 7'h33};
            1:  w = {7'h00, rb, ra, 3'd4, rd, 7'h33};
            2:  w = {7'h00, rb, ra, 3'd1, rd, 7'h33};
            3:  w = {7'h00, rb, ra, 3'd0, rd, 7'h33};
            4:  w = {7'h20, rb, ra, 3'd0, rd, 7'h33};
            5:  w = {7'h01, rb, ra, 3'd0, rd, 7'h33};
            6:  w = {imm, ra, 3'd0, rd, 7'h13};
            7:  w = {7'h20, rb, ra, 3'd5, rd, 7'h13};
            8:  w = {imm, ra, 3'd2, rd, 7'h03};
            9:  w = {imm[11:5], rb, ra, 3'd2, imm[4:0], 7'h23};
            10: w = {imm[11:5], rb, ra, 3'd0, imm[4:0], 7'h63};
            11: w = {7'h00, rb, ra, 3'd2, rd, 7'h33};
            12: w = {7'h00, rb, ra, 3'd5, rd, 7'h13};
            13: w = {imm, ra, 3'd3, rd, 7'h7F};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // Model: occupancy is the queue length; flush empties it outright
    always @(posedge clk_i) begin : model_upd
        bit acc;
        bit pp;
        if (rst_i) begin
            acc = valid_i && (mq.size() < 2);
            pp  = (mq.size() > 0) && ready_i;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (pp)  void'(mq.pop_front());
                if (acc) mq.push_back(ref_decode(instr_i, rs1_data_i, rs2_data_i));
            end
        end else begin
            mq.delete();
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk_i) begin
        if (chk_en && rst_i) begin
            check("m_valid", valid_o, mq.size() != 0);
            check("m_ready", ready_o, mq.size() < 2);
            if (mq.size() != 0) begin
                check("m_ctrl", ALUCtrl_o, mq[0].ctrl);
                check("m_data1", data1_o, mq[0].d1);
                check("m_data2", data2_o, mq[0].d2);
                check("m_illegal", illegal_o, mq[0].ill);
            end
        end
    end

    initial begin
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        flush_i    = 1'b0;
        instr_i    = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        rst_i      = 1'b1;
        #1 rst_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_ctrl", ALUCtrl_o, 0);
        check("rst_data1", data1_o, 0);
        check("rst_data2", data2_o, 0);
        check("rst_illegal", illegal_o, 0);
        rst_i  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk_i);
        check("idle_valid", valid_o, 0);
        check("idle_ready", ready_o, 1);
        check("idle_ctrl", ALUCtrl_o, 0);

        // Single SUB
        valid_i = 1'b1; ready_i = 1'b1;
        instr_i = 32'h4020_8033; rs1_data_i = 32'd10; rs2_data_i = 32'd3;
        @(negedge clk_i);
        valid_i = 1'b0;
        expect_head("sub", 4'b0100, 32'd10, 32'd3, 1'b0);
        @(negedge clk_i);
        check("sub_clear", valid_o, 0);

        // SRAI then SW with imm -8, back to back
        valid_i = 1'b1;
        instr_i = 32'h4040_D093; rs1_data_i = 32'hFFFF_FF00; rs2_data_i = 32'h0;
        @(negedge clk_i);
        instr_i = {7'h7F, 5'd2, 5'd1, 3'b010, 5'b11000, 7'b0100011};
        rs1_data_i = 32'h1000; rs2_data_i = 32'h55;
        expect_head("srai", 4'b0111, 32'hFFFF_FF00, 32'd4, 1'b0);
        @(negedge clk_i);
        valid_i = 1'b0;
        expect_head("sw", 4'b1000, 32'h1000, 32'hFFFF_FFF8, 1'b0);
        @(negedge clk_i);

        // Back-pressure: three offered, ready_i low for four cycles
        ready_i = 1'b0; valid_i = 1'b1;
        instr_i = 32'h0020_8033; rs1_data_i = 32'h111; rs2_data_i = 32'h1;
        @(negedge clk_i);
        check("bp_ready1", ready_o, 1);
        expect_head("bp_i0a", 4'b0011, 32'h111, 32'h1, 1'b0);
        instr_i = 32'h0020_C033; rs1_data_i = 32'h222; rs2_data_i = 32'h2;
        @(negedge clk_i);
        check("bp_full", ready_o, 0);
        expect_head("bp_i0b", 4'b0011, 32'h111, 32'h1, 1'b0);
        instr_i = 32'h0020_F033; rs1_data_i = 32'h333; rs2_data_i = 32'h3;
        @(negedge clk_i);
        check("bp_hold1", ready_o, 0);
        @(negedge clk_i);
        check("bp_hold2", ready_o, 0);
        expect_head("bp_i0c", 4'b0011, 32'h111, 32'h1, 1'b0);
        ready_i = 1'b1;
        @(negedge clk_i);
        expect_head("bp_i1", 4'b0001, 32'h222, 32'h2, 1'b0);
        check("bp_ready2", ready_o, 1);
        @(negedge clk_i);
        valid_i = 1'b0;
        expect_head("bp_i2", 4'b0000, 32'h333, 32'h3, 1'b0);
        @(negedge clk_i);
        check("bp_drained", valid_o, 0);

        // Flush with two buffered entries and upstream still offering
        ready_i = 1'b0; valid_i = 1'b1;
        instr_i = 32'h0220_8033; rs1_data_i = 32'hAAA; rs2_data_i = 32'hBBB;
        @(negedge clk_i);
        instr_i = 32'h0020_9033; rs1_data_i = 32'hCCC;
        @(negedge clk_i);
        check("fl_full", ready_o, 0);
        flush_i = 1'b1;
        instr_i = 32'h0050_0093;
        @(negedge clk_i);
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("fl_valid", valid_o, 0);
        check("fl_ready", ready_o, 1);
        ready_i = 1'b1;
        @(negedge clk_i);
        check("fl_gone", valid_o, 0);

        // Flush with one entry and a live accept: the accept is dropped
        ready_i = 1'b0; valid_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; valid_i = 1'b0;
        check("fl1_valid", valid_o, 0);

        // Undefined opcode
        valid_i = 1'b1; ready_i = 1'b1;
        instr_i = 32'h0000_007F; rs1_data_i = 32'd5; rs2_data_i = 32'd6;
        @(negedge clk_i);
        valid_i = 1'b0;
        expect_head("illegal", 4'b0011, 32'd0, 32'd0, 1'b1);
        @(negedge clk_i);

        // Asynchronous reset while stalled and full
        ready_i = 1'b0; valid_i = 1'b1;
        instr_i = 32'h0020_8033; rs1_data_i = 32'h77; rs2_data_i = 32'h88;
        repeat (2) @(negedge clk_i);
        valid_i = 1'b0;
        check("ar_before", valid_o, 1);
        #2 rst_i = 1'b0;
        mq.delete();
        #1;
        check("ar_valid", valid_o, 0);
        check("ar_ready", ready_o, 1);
        check("ar_ctrl", ALUCtrl_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Randomized traffic against the model
        repeat (600) begin
            valid_i    = ($urandom_range(0, 9) < 7);
            ready_i    = ($urandom_range(0, 9) < 6);
            flush_i    = ($urandom_range(0, 19) == 0);
            instr_i    = rand_instr();
            rs1_data_i = $urandom;
            rs2_data_i = $urandom;
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
